// File: rtl/i2c_pwm_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pwm_pkg
// Shared definitions for the I2C-controlled PWM duty register block.
//   state_t               : protocol states of the I2C slave FSM
//   I2C_PWM_NUM_CH_MAX    : largest channel count the pointer decode supports
//   I2C_PWM_DEFAULT_ADDR  : default 7-bit slave address
//   byte_t                : one I2C data byte
// Optional build macro used by the top level: I2C_PWM_SHADOW_EN
// ----------------------------------------------------------------------------
package i2c_pwm_pkg;

   localparam int I2C_PWM_NUM_CH_MAX = 16;
   localparam logic [6:0] I2C_PWM_DEFAULT_ADDR = 7'h42;

   typedef logic [7:0] byte_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_REG,
      ST_REG_ACK,
      ST_WDATA,
      ST_WACK,
      ST_RDATA,
      ST_RACK,
      ST_IGNORE
   } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// ----------------------------------------------------------------------------
// i2c_bus_sync
// Brings the asynchronous SCL/SDA pins into the clk domain and derives the
// bus events the slave FSM works from.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   scl_i/sda_i : raw bus pins
//   scl_rise    : one-clk pulse on a synchronized SCL rising edge
//   scl_fall    : one-clk pulse on a synchronized SCL falling edge
//   start_det   : one-clk pulse when SDA falls while SCL is high
//   stop_det    : one-clk pulse when SDA rises while SCL is high
//   sda_s       : synchronized SDA level
// ----------------------------------------------------------------------------
module i2c_bus_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [1:0] sclSync;
   logic [1:0] sdaSync;
   logic       sclPrev;
   logic       sdaPrev;
   logic       sclS;

   // Two flops per pin for metastability, then one more flop of history so
   // edges can be seen. Everything resets to the idle-bus level (high) so
   // leaving reset never looks like a START, STOP or SCL edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclSync <= 2'b11;
         sdaSync <= 2'b11;
         sclPrev <= 1'b1;
         sdaPrev <= 1'b1;
      end else begin
         sclSync <= {sclSync[0], scl_i};
         sdaSync <= {sdaSync[0], sda_i};
         sclPrev <= sclSync[1];
         sdaPrev <= sdaSync[1];
      end
   end

   // START/STOP require SCL to have been high on both samples so that an
   // SDA change made right at an SCL edge is never mistaken for a condition.
   always_comb begin
      sclS      = sclSync[1];
      sda_s     = sdaSync[1];
      scl_rise  = sclS & ~sclPrev;
      scl_fall  = ~sclS & sclPrev;
      start_det = sclS & sclPrev & sdaPrev & ~sda_s;
      stop_det  = sclS & sclPrev & ~sdaPrev & sda_s;
   end

endmodule

// File: rtl/i2c_pwm_regs.sv
// ----------------------------------------------------------------------------
// i2c_pwm_regs
// I2C slave holding one duty byte per LED PWM channel. A write transaction
// sends a pointer byte followed by data bytes (pointer auto-increments with
// wrap); a read transaction returns bytes from the current pointer.
// Parameters:
//   I2C_ADDR : 7-bit slave address
//   NUM_CH   : number of duty registers (power of two, 2..16)
//   DUTY_W   : duty register width, must be 8
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   scl_i      : SCL pin input
//   sda_i      : SDA pin input
//   sda_oe     : 1 pulls SDA low, 0 releases it
//   duty       : channel n at bits [n*8+7 : n*8]
//   update     : one-clk pulse whenever duty changes
//   busy       : high from the address ACK until the next START/STOP
// Build option I2C_PWM_SHADOW_EN: writes land in a shadow bank and are
// committed to duty together on STOP. Without it each byte goes straight
// to duty.
// ----------------------------------------------------------------------------
module i2c_pwm_regs
   import i2c_pwm_pkg::*;
#(
   parameter logic [6:0] I2C_ADDR = I2C_PWM_DEFAULT_ADDR,
   parameter int         NUM_CH   = 8,
   parameter int         DUTY_W   = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     scl_i,
   input  logic                     sda_i,
   output logic                     sda_oe,
   output logic [NUM_CH*DUTY_W-1:0] duty,
   output logic                     update,
   output logic                     busy
);

   localparam int    PTR_W    = $clog2(NUM_CH);
   localparam byte_t NUM_CH_B = byte_t'(NUM_CH);

   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;
   logic sda_s;

   state_t           state;
   logic [3:0]       bitCnt;
   byte_t            shiftReg;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptrNext;
   logic             rwBit;
   byte_t            rxByte;
   byte_t            dutyReg [NUM_CH];

`ifdef I2C_PWM_SHADOW_EN
   byte_t            shadow [NUM_CH];
   logic             dirty;
`endif

   i2c_bus_sync u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_i     (scl_i),
      .sda_i     (sda_i),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   // The byte as it will look once the bit now on SDA is shifted in, and the
   // pointer value used when a write or read moves on to the next channel
   // (wraps naturally because NUM_CH is a power of two).
   always_comb begin
      rxByte  = {shiftReg[6:0], sda_s};
      ptrNext = ptr + PTR_W'(1);
   end

   // Flatten the register bank onto the duty bus feeding the PWM channels.
   for (genvar n = 0; n < NUM_CH; n++) begin : g_duty
      assign duty[n*DUTY_W +: DUTY_W] = dutyReg[n];
   end

   // Protocol FSM. STOP and START override whatever is in progress, so a
   // partially received byte is simply dropped. Bits are taken on SCL rising
   // edges; sda_oe only moves on SCL falling edges so SDA is stable while SCL
   // is high. The ACK states use sda_oe itself to tell the falling edge that
   // starts the ACK bit from the one that ends it. In the read path bitCnt
   // counts bits sent, and in RACK it marks that the master's ACK was seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         bitCnt   <= '0;
         shiftReg <= '0;
         ptr      <= '0;
         rwBit    <= 1'b0;
         sda_oe   <= 1'b0;
         busy     <= 1'b0;
         update   <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            dutyReg[i] <= '0;
         end
`ifdef I2C_PWM_SHADOW_EN
         for (int i = 0; i < NUM_CH; i++) begin
            shadow[i] <= '0;
         end
         dirty    <= 1'b0;
`endif
      end else begin
         update <= 1'b0;
         if (stop_det) begin
            state  <= ST_IDLE;
            bitCnt <= '0;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
`ifdef I2C_PWM_SHADOW_EN
            if (dirty) begin
               for (int i = 0; i < NUM_CH; i++) begin
                  dutyReg[i] <= shadow[i];
               end
               update <= 1'b1;
               dirty  <= 1'b0;
            end
`endif
         end else if (start_det) begin
            state  <= ST_ADDR;
            bitCnt <= '0;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
`ifdef I2C_PWM_SHADOW_EN
            if (state == ST_IDLE) begin
               for (int i = 0; i < NUM_CH; i++) begin
                  shadow[i] <= dutyReg[i];
               end
               dirty <= 1'b0;
            end
`endif
         end else begin
            case (state)
               ST_ADDR: begin
                  if (scl_rise) begin
                     shiftReg <= rxByte;
                     bitCnt   <= bitCnt + 4'd1;
                     if (bitCnt == 4'd7) begin
                        bitCnt <= '0;
                        rwBit  <= rxByte[0];
                        state  <= (rxByte[7:1] == I2C_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                     end
                  end
               end

               ST_ADDR_ACK: begin
                  if (scl_fall) begin
                     if (!sda_oe) begin
                        sda_oe <= 1'b1;
                        busy   <= 1'b1;
                     end else if (rwBit) begin
                        shiftReg <= dutyReg[ptr];
                        sda_oe   <= ~dutyReg[ptr][7];
                        bitCnt   <= '0;
                        state    <= ST_RDATA;
                     end else begin
                        sda_oe <= 1'b0;
                        bitCnt <= '0;
                        state  <= ST_REG;
                     end
                  end
               end

               ST_REG: begin
                  if (scl_rise) begin
                     shiftReg <= rxByte;
                     bitCnt   <= bitCnt + 4'd1;
                     if (bitCnt == 4'd7) begin
                        bitCnt <= '0;
                        if (rxByte < NUM_CH_B) begin
                           ptr   <= rxByte[PTR_W-1:0];
                           state <= ST_REG_ACK;
                        end else begin
                           state <= ST_IGNORE;
                        end
                     end
                  end
               end

               ST_REG_ACK: begin
                  if (scl_fall) begin
                     if (!sda_oe) begin
                        sda_oe <= 1'b1;
                     end else begin
                        sda_oe <= 1'b0;
                        bitCnt <= '0;
                        state  <= ST_WDATA;
                     end
                  end
               end

               ST_WDATA: begin
                  if (scl_rise) begin
                     shiftReg <= rxByte;
                     bitCnt   <= bitCnt + 4'd1;
                     if (bitCnt == 4'd7) begin
                        bitCnt <= '0;
                        state  <= ST_WACK;
`ifdef I2C_PWM_SHADOW_EN
                        shadow[ptr] <= rxByte;
                        dirty       <= 1'b1;
`else
                        dutyReg[ptr] <= rxByte;
                        update       <= 1'b1;
`endif
                     end
                  end
               end

               ST_WACK: begin
                  if (scl_fall) begin
                     if (!sda_oe) begin
                        sda_oe <= 1'b1;
                     end else begin
                        sda_oe <= 1'b0;
                        ptr    <= ptrNext;
                        bitCnt <= '0;
                        state  <= ST_WDATA;
                     end
                  end
               end

               ST_RDATA: begin
                  if (scl_rise) begin
                     bitCnt <= bitCnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bitCnt == 4'd8) begin
                        sda_oe <= 1'b0;
                        bitCnt <= '0;
                        state  <= ST_RACK;
                     end else begin
                        shiftReg <= {shiftReg[6:0], 1'b0};
                        sda_oe   <= ~shiftReg[6];
                     end
                  end
               end

               ST_RACK: begin
                  if (scl_rise) begin
                     if (sda_s) begin
                        state <= ST_IGNORE;
                     end else begin
                        bitCnt <= 4'd1;
                     end
                  end else if (scl_fall && bitCnt == 4'd1) begin
                     ptr      <= ptrNext;
                     shiftReg <= dutyReg[ptrNext];
                     sda_oe   <= ~dutyReg[ptrNext][7];
                     bitCnt   <= '0;
                     state    <= ST_RDATA;
                  end
               end

               ST_IGNORE: begin
                  sda_oe <= 1'b0;
               end

               default: begin
                  sda_oe <= 1'b0;
                  state  <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_pwm_regs.sv
// ----------------------------------------------------------------------------
// tb_i2c_pwm_regs
// Directed bench for i2c_pwm_regs: a bit-banged I2C master on an open-drain
// SDA wire, driving write/read transactions with hand-computed expectations.
// Honours I2C_PWM_SHADOW_EN for the commit-timing expectations.
// ----------------------------------------------------------------------------
module tb_i2c_pwm_regs;

   localparam int Q = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        masterScl = 1'b1;
   logic        masterSda = 1'b1;
   logic        sdaBus;
   logic        sda_oe;
   logic        update;
   logic        busy;
   logic [63:0] duty;

   int   checkCount = 0;
   int   passCount = 0;
   int   failCount = 0;
   int   updateCount = 0;
   int   updBase;
   logic busySeen = 1'b0;
   logic ack;
   logic [7:0] rdByte;

   // Open-drain bus: either side can pull SDA low.
   assign sdaBus = masterSda & ~sda_oe;

   always #5 clk = ~clk;

   i2c_pwm_regs #(
      .I2C_ADDR (7'h42),
      .NUM_CH   (8),
      .DUTY_W   (8)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .scl_i  (masterScl),
      .sda_i  (sdaBus),
      .sda_oe (sda_oe),
      .duty   (duty),
      .update (update),
      .busy   (busy)
   );

   // Count update pulses and remember whether busy was ever raised.
   always @(negedge clk) begin
      if (update) updateCount++;
      if (busy) busySeen = 1'b1;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      assert (observed === expected) begin
         passCount++;
      end else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One SCL clock: set SDA while SCL is low, sample it mid-high.
   task automatic applyStimulus(input logic bitVal, output logic sampled);
      repeat (Q) @(negedge clk);
      masterSda = bitVal;
      repeat (Q) @(negedge clk);
      masterScl = 1'b1;
      repeat (Q) @(negedge clk);
      sampled = sdaBus;
      repeat (Q) @(negedge clk);
      masterScl = 1'b0;
   endtask

   task automatic i2cStart();
      masterSda = 1'b1;
      repeat (Q) @(negedge clk);
      masterScl = 1'b1;
      repeat (Q) @(negedge clk);
      masterSda = 1'b0;
      repeat (Q) @(negedge clk);
      masterScl = 1'b0;
   endtask

   task automatic i2cStop();
      repeat (Q) @(negedge clk);
      masterSda = 1'b0;
      repeat (Q) @(negedge clk);
      masterScl = 1'b1;
      repeat (Q) @(negedge clk);
      masterSda = 1'b1;
      repeat (2 * Q) @(negedge clk);
   endtask

   task automatic writeByte(input logic [7:0] b, output logic gotAck);
      logic s;
      for (int i = 7; i >= 0; i--) applyStimulus(b[i], s);
      applyStimulus(1'b1, s);
      gotAck = ~s;
   endtask

   task automatic readByte(input logic giveAck, output logic [7:0] b);
      logic s;
      b = '0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, s);
         b = {b[6:0], s};
      end
      applyStimulus(~giveAck, s);
   endtask

   initial begin
      // Reset values
      repeat (4) @(negedge clk);
      checkOutput("rstDuty", duty, 64'h0);
      checkOutput("rstSdaOe", {63'h0, sda_oe}, 64'h0);
      checkOutput("rstUpdate", {63'h0, update}, 64'h0);
      checkOutput("rstBusy", {63'h0, busy}, 64'h0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Single write: ch2 = 0x55
      updBase = updateCount;
      busySeen = 1'b0;
      i2cStart();
      writeByte(8'h84, ack); checkOutput("t1AddrAck", {63'h0, ack}, 64'h1);
      writeByte(8'h02, ack); checkOutput("t1PtrAck", {63'h0, ack}, 64'h1);
      writeByte(8'h55, ack); checkOutput("t1DataAck", {63'h0, ack}, 64'h1);
      i2cStop();
      checkOutput("t1Duty", duty, 64'h0000_0000_0055_0000);
      checkOutput("t1Updates", 64'(updateCount - updBase), 64'd1);
      checkOutput("t1BusySeen", {63'h0, busySeen}, 64'h1);
      checkOutput("t1BusyAfterStop", {63'h0, busy}, 64'h0);

      // Pointer wrap: ch6, ch7, ch0
      updBase = updateCount;
      i2cStart();
      writeByte(8'h84, ack); checkOutput("t2AddrAck", {63'h0, ack}, 64'h1);
      writeByte(8'h06, ack); checkOutput("t2PtrAck", {63'h0, ack}, 64'h1);
      writeByte(8'h11, ack); checkOutput("t2D0Ack", {63'h0, ack}, 64'h1);
      writeByte(8'h22, ack); checkOutput("t2D1Ack", {63'h0, ack}, 64'h1);
      writeByte(8'h33, ack); checkOutput("t2D2Ack", {63'h0, ack}, 64'h1);
      i2cStop();
      checkOutput("t2Duty", duty, 64'h2211_0000_0055_0033);
`ifdef I2C_PWM_SHADOW_EN
      checkOutput("t2Updates", 64'(updateCount - updBase), 64'd1);
`else
      checkOutput("t2Updates", 64'(updateCount - updBase), 64'd3);
`endif

      // Load ch3/ch4 so the read-back is meaningful
      i2cStart();
      writeByte(8'h84, ack); checkOutput("t3aAddrAck", {63'h0, ack}, 64'h1);
      writeByte(8'h03, ack); checkOutput("t3aPtrAck", {63'h0, ack}, 64'h1);
      writeByte(8'h3C, ack); checkOutput("t3aD0Ack", {63'h0, ack}, 64'h1);
      writeByte(8'hC4, ack); checkOutput("t3aD1Ack", {63'h0, ack}, 64'h1);
      i2cStop();
      checkOutput("t3aDuty", duty, 64'h2211_00C4_3C55_0033);

      // Pointer write, repeated START, read two bytes
      i2cStart();
      writeByte(8'h84, ack); checkOutput("t3bAddrAck", {63'h0, ack}, 64'h1);
      writeByte(8'h03, ack); checkOutput("t3bPtrAck", {63'h0, ack}, 64'h1);
      i2cStart();
      writeByte(8'h85, ack); checkOutput("t3bRdAddrAck", {63'h0, ack}, 64'h1);
      readByte(1'b1, rdByte); checkOutput("t3bRead0", {56'h0, rdByte}, 64'h3C);
      readByte(1'b0, rdByte); checkOutput("t3bRead1", {56'h0, rdByte}, 64'hC4);
      repeat (6) @(negedge clk);
      checkOutput("t3bSdaReleased", {63'h0, sda_oe}, 64'h0);
      i2cStop();

      // Wrong address: no ACK, busy never raised
      busySeen = 1'b0;
      i2cStart();
      writeByte(8'h80, ack); checkOutput("t4aAddrNack", {63'h0, ack}, 64'h0);
      i2cStop();
      checkOutput("t4aBusySeen", {63'h0, busySeen}, 64'h0);
      checkOutput("t4aDuty", duty, 64'h2211_00C4_3C55_0033);

      // Out-of-range pointer: NACK, following data ignored
      i2cStart();
      writeByte(8'h84, ack); checkOutput("t4bAddrAck", {63'h0, ack}, 64'h1);
      writeByte(8'h09, ack); checkOutput("t4bPtrNack", {63'h0, ack}, 64'h0);
      writeByte(8'hEE, ack); checkOutput("t4bDataNack", {63'h0, ack}, 64'h0);
      i2cStop();
      checkOutput("t4bDuty", duty, 64'h2211_00C4_3C55_0033);

      // Two-byte write: commit timing depends on the shadow option
      updBase = updateCount;
      i2cStart();
      writeByte(8'h84, ack); checkOutput("t5AddrAck", {63'h0, ack}, 64'h1);
      writeByte(8'h00, ack); checkOutput("t5PtrAck", {63'h0, ack}, 64'h1);
      writeByte(8'hAA, ack); checkOutput("t5D0Ack", {63'h0, ack}, 64'h1);
`ifdef I2C_PWM_SHADOW_EN
      checkOutput("t5MidCh0", {56'h0, duty[7:0]}, 64'h33);
`else
      checkOutput("t5MidCh0", {56'h0, duty[7:0]}, 64'hAA);
`endif
      writeByte(8'hBB, ack); checkOutput("t5D1Ack", {63'h0, ack}, 64'h1);
`ifdef I2C_PWM_SHADOW_EN
      checkOutput("t5MidUpdates", 64'(updateCount - updBase), 64'd0);
`else
      checkOutput("t5MidUpdates", 64'(updateCount - updBase), 64'd2);
`endif
      i2cStop();
      checkOutput("t5Duty", duty, 64'h2211_00C4_3C55_BBAA);
`ifdef I2C_PWM_SHADOW_EN
      checkOutput("t5Updates", 64'(updateCount - updBase), 64'd1);
`else
      checkOutput("t5Updates", 64'(updateCount - updBase), 64'd2);
`endif

      // Reset while the slave is driving a read bit (ch2 = 0x55, MSB 0)
      i2cStart();
      writeByte(8'h85, ack); checkOutput("t6AddrAck", {63'h0, ack}, 64'h1);
      repeat (6) @(negedge clk);
      checkOutput("t6DrivingMsb", {63'h0, sda_oe}, 64'h1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6RstSdaOe", {63'h0, sda_oe}, 64'h0);
      checkOutput("t6RstDuty", duty, 64'h0);
      checkOutput("t6RstBusy", {63'h0, busy}, 64'h0);
      @(negedge clk);
      masterScl = 1'b1;
      masterSda = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Next transaction after reset works normally
      i2cStart();
      writeByte(8'h84, ack); checkOutput("t7AddrAck", {63'h0, ack}, 64'h1);
      writeByte(8'h02, ack); checkOutput("t7PtrAck", {63'h0, ack}, 64'h1);
      writeByte(8'h55, ack); checkOutput("t7DataAck", {63'h0, ack}, 64'h1);
      i2cStop();
      checkOutput("t7Duty", duty, 64'h0000_0000_0055_0000);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/i2c_pwm_regs.md
# i2c_pwm_regs

I2C slave register controller that configures the PWM duty values for the LED PWM channels. Oversamples SCL/SDA in the system `clk` domain, decodes 7-bit-addressed write/read transactions, and holds one duty byte per channel. The `duty` bus feeds the `value` inputs of the `pwm_module` instances. This replaces the current hard-coded initial ramp and the stub I2C slave.

## Interface
- `I2C_ADDR`, 7'h42, 7-bit slave address matched
- `NUM_CH`, 8, number of duty registers (power of two, 2..16)
- `DUTY_W`, 8, duty register width (fixed byte transfers; must be 8)
- `clk`  in  1  system clock (12 MHz on board)
- `rst_n`  in  1  asynchronous active-low reset
- `scl_i`  in  1  SCL pin input (asynchronous)
- `sda_i`  in  1  SDA pin input (asynchronous)
- `sda_oe`  out  1  1 = drive SDA low; 0 = release (open-drain at top)
- `duty`  out  NUM_CH*DUTY_W  channel n at bits [n*8+7 : n*8]
- `update`  out  1  one-cycle pulse when `duty` changes
- `busy`  out  1  high from matched-address ACK to STOP/START

## Operation
- Reset values: `duty` all 0, `sda_oe` 0, `update` 0, `busy` 0, pointer 0, state IDLE.
- Reset is asynchronous. Assertion mid-transaction releases SDA immediately and discards all staged data.
- START: SDA falling while SCL high. STOP: SDA rising while SCL high. Both are detected in any state.
- START or repeated START goes to ADDR. STOP goes to IDLE.
- Data bits are sampled on synchronized SCL rising edges, MSB first. `sda_oe` changes only on synchronized SCL falling edges.
- States:
  - IDLE
  - ADDR: 8 bits. Address match → ADDR_ACK. Mismatch → IGNORE.
  - ADDR_ACK: R/W=0 → REG; R/W=1 → RDATA.
  - REG: pointer byte. Value < NUM_CH → REG_ACK, pointer loaded. Otherwise NACK → IGNORE.
  - REG_ACK → WDATA.
  - WDATA: byte captured into register[pointer] → WACK.
  - WACK: pointer increments modulo NUM_CH (wraps 7→0 when NUM_CH=8) → WDATA.
  - RDATA: drive register[pointer] MSB first (`sda_oe` = ~bit) → RACK.
  - RACK: release SDA and sample master ACK. ACK → pointer++, RDATA. NACK → IGNORE.
  - IGNORE: SDA released; wait for START/STOP.
- ACK means `sda_oe`=1 for the 9th clock.
- Pointer is retained across repeated START, so a write of the pointer followed by a repeated-START read returns from that pointer.
- Reads return committed `duty` values, not staged ones.
- START arriving mid-byte aborts the byte: the partial byte is not written and the pointer is unchanged.

## Timing
- Input path: 2-FF synchronizer plus 1 edge-detect register, giving 3 `clk` of latency.
- Requirement: `clk` ≥ 16× SCL frequency (12 MHz supports 400 kHz).
- `sda_oe` transitions no later than 4 `clk` after SCL falls on the bus pin.
- Direct mode: `duty` and `update` change 1 `clk` after the SCL rising edge that samples bit 0 of a data byte.
- `busy` rises with the ADDR_ACK `sda_oe` assertion and falls 1 `clk` after START/STOP detection.

## Configuration
- `I2C_PWM_SHADOW_EN` defined:
  - Writes go to a shadow bank loaded from `duty` at every START from IDLE.
  - A STOP following at least one completed data byte copies the shadow bank to `duty` and pulses `update` once, 1 `clk` after STOP detection.
  - Repeated START does not commit. The eventual STOP commits all bytes written in the transaction.
- Undefined: each completed data byte writes `duty` directly and pulses `update` per byte. No shadow bank is built.

## Structure
- Package `i2c_pwm_pkg`: state enum, `I2C_PWM_NUM_CH_MAX`, default address constant, byte type.
- Sub-module `i2c_bus_sync`:
  - Synchronizers for SCL/SDA.
  - Outputs: `scl_rise`, `scl_fall`, `start_det`, `stop_det`, `sda_s`.
- Top-level FSM, shift register, bit counter (0–8), pointer, and register bank live in `i2c_pwm_regs`.

## Test plan
- Write 0x84, ptr 0x02, data 0x55, STOP → ACKs on all three bytes; `duty[23:16]`=0x55; others 0; exactly one `update`.
- Write ptr 0x06, data 0x11, 0x22, 0x33 → ch6=0x11, ch7=0x22, ch0=0x33 (wrap).
- Write ptr 0x03, repeated START, read 0x85, two bytes with ACK then NACK → returns ch3, ch4; `sda_oe` released after the NACK.
- Address 0x40 write → no ACK; `busy` stays 0; `duty` unchanged. Pointer 0x09 → NACK; `duty` unchanged.
- `I2C_PWM_SHADOW_EN`: write ch0=0xAA, ch1=0xBB → `duty` unchanged until STOP, then both change in the same cycle with a single `update`. Without the macro, two `update` pulses.
- `rst_n` low mid-data byte → `sda_oe`=0 immediately; after reset `duty`=0 and the next valid transaction succeeds.
